scie_fir_pipelined: RTL and testbench
=====================================

Name: scie_fir_pipelined

Overview:
- SCIE custom-instruction datapath implementing a 5-tap FIR filter state machine, attached to the core's custom opcode space.
- The core issues one instruction per cycle with operands rs1/rs2.
- The block updates coefficient and sample-history registers.
- Read instructions return a registered result on io_rd one cycle later.

Parameters:
- NTAPS, 5, number of coefficients and sample-history entries.
- XLEN, 32, operand/result width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (clears all state while low)
- io_insn  in  32  instruction word; bits[6:0] opcode, bits[14:12] funct3
- io_valid  in  1  instruction in io_insn/io_rs1/io_rs2 is valid this cycle
- io_rs1  in  32  signed operand 1 (coefficient value or sample)
- io_rs2  in  32  operand 2 (coefficient index)
- io_rd  out  32  signed result, registered

Behaviour:
- State:
  - coefficient regs c[0..4], signed 32b
  - sample history h[0..4], signed 32b (h[0] newest)
  - result reg r driving io_rd
- Reset (reset low, asynchronous): c, h and r all cleared to 0; io_rd = 0.
- Decode occurs only when io_valid=1 at a rising clock edge. Unknown opcodes, or io_valid=0, change nothing; r holds its value.
- Opcode 0x0B (custom-0), SET_COEF:
  - if io_rs2 < NTAPS then c[io_rs2[2:0]] <= io_rs1
  - else ignored
  - r unchanged
- Opcode 0x2B (custom-1), PUSH:
  - h[0] <= io_rs1; h[i] <= h[i-1] for i=1..4; h[4] is discarded
  - r unchanged
- Opcode 0x5B (custom-2), READ, selected by funct3:
  - funct3=0: r <= h[1], the sample pushed before the most recent push (0 if fewer than two pushes since reset).
  - funct3=1: r <= low 32 bits of sum over i of c[i]*h[i]. Signed 32x32 multiplies; accumulation is wrap-around modulo 2^32, no saturation.
  - funct3=2: r <= c[io_rs2] if io_rs2 < NTAPS, else 0.
  - other funct3: r unchanged.
- Latency:
  - io_rd reflects a READ on the first rising edge after issue, i.e. valid in the following cycle.
  - io_rd holds that value until the next READ or reset.
- io_rs1/io_rs2 values during a READ do not affect funct3=0/1 results.
- History updates after a PUSH are visible to a READ issued in any later cycle, including back-to-back.
- Only one instruction per cycle, so there are no simultaneous-event conflicts.
- Reset asserted mid-sequence discards all history and coefficients.

Decomposition:
- Package scie_fir_pkg holds:
  - opcode constants OP_SET_COEF=7'h0B, OP_PUSH=7'h2B, OP_READ=7'h5B
  - funct3 constants RD_PREV=0, RD_FIR=1, RD_COEF=2
  - NTAPS
  - signed 32b data typedef
- Optional sub-module scie_fir_mac: combinational 5-term multiply-accumulate of c[] and h[] returning a 32b wrap-around sum.

Test Plan:
- Reset, then READ funct3=0 -> io_rd=0 the next cycle; verify io_rd=0 throughout reset.
- SET_COEF with rs2=0..4, rs1=4193776, 213188, 104368, 3111167, 2030295; then READ funct3=2 with rs2=3 -> io_rd=3111167; rs2=7 -> io_rd=0.
- PUSH 323244, idle cycle, READ funct3=0 -> io_rd=0. PUSH 6076607, idle, READ -> 323244. PUSH 5578861, idle, READ -> 6076607. Continue the pattern for 20 pushes; each read returns the previous sample.
- Set c={1,2,3,0,0}, PUSH 10, 20, 30, READ funct3=1 -> io_rd = 1*30 + 2*20 + 3*10 = 100. Set c[0]=32'h7FFFFFFF, h[0]=2 -> verify wrap-around result.
- Hold behaviour and invalid decode:
  - io_valid=0 with opcode 0x5B -> io_rd unchanged
  - opcode 0x33 -> no state change
- Assert reset low asynchronously mid-sequence -> io_rd drops to 0 immediately; a READ afterwards returns 0.

Source files
------------

// File: rtl/scie_fir_pkg.sv
// Shared constants and types for the SCIE 5-tap FIR custom-instruction datapath.
// Opcode/funct3 encodings, tap count and the signed data word.
package scie_fir_pkg;

    localparam int NTAPS = 5;
    localparam int XLEN  = 32;

    localparam logic [6:0] OP_SET_COEF = 7'h0B;
    localparam logic [6:0] OP_PUSH     = 7'h2B;
    localparam logic [6:0] OP_READ     = 7'h5B;

    localparam logic [2:0] RD_PREV = 3'd0;
    localparam logic [2:0] RD_FIR  = 3'd1;
    localparam logic [2:0] RD_COEF = 3'd2;

    typedef logic signed [XLEN-1:0] data_t;

endpackage

// File: rtl/scie_fir_mac.sv
// Purpose: combinational dot product of coefficients and history, wrapped to 32 bits.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs continuously.
module scie_fir_mac
    import scie_fir_pkg::*;
(
    input  data_t coef [NTAPS],
    input  data_t hist [NTAPS],
    output data_t sum
);

    // Low 32 bits of each product are identical for signed and unsigned
    // multiplies, so a 32-bit accumulator gives the modulo-2^32 result directly.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NTAPS; i++) begin
            sum = sum + coef[i] * hist[i];
        end
    end

endmodule

// File: rtl/scie_fir_pipelined.sv
// Purpose: SCIE custom-instruction FIR block (SET_COEF / PUSH / READ) on custom-0..2 opcodes.
// Latency: READ result appears on io_rd one clock after issue and holds until the next READ.
// Backpressure: none; accepts one instruction every cycle while io_valid is high.
module scie_fir_pipelined
    import scie_fir_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     io_insn,
    input  logic            io_valid,
    input  logic [31:0]     io_rs1,
    input  logic [31:0]     io_rs2,
    output logic [31:0]     io_rd
);

    data_t      coef [NTAPS];
    data_t      hist [NTAPS];
    data_t      r;
    data_t      fir_sum;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       idx_ok;
    logic [2:0] idx;

    // Remaining instruction fields carry nothing this block decodes.
    logic       unused_insn;
    assign unused_insn = &{1'b0, io_insn[31:15], io_insn[11:7]};

    assign opcode = io_insn[6:0];
    assign funct3 = io_insn[14:12];
    assign idx_ok = io_rs2 < 32'(NTAPS);
    assign idx    = io_rs2[2:0];

    scie_fir_mac u_mac (
        .coef (coef),
        .hist (hist),
        .sum  (fir_sum)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef[i] <= '0;
                hist[i] <= '0;
            end
            r <= '0;
        end else if (io_valid) begin
            case (opcode)
                OP_SET_COEF: begin
                    if (idx_ok) begin
                        coef[idx] <= io_rs1;
                    end
                end
                OP_PUSH: begin
                    hist[0] <= io_rs1;
                    for (int i = 1; i < NTAPS; i++) begin
                        hist[i] <= hist[i-1];
                    end
                end
                OP_READ: begin
                    case (funct3)
                        RD_PREV: r <= hist[1];
                        RD_FIR:  r <= fir_sum;
                        RD_COEF: r <= idx_ok ? coef[idx] : '0;
                        default: r <= r;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign io_rd = r;

endmodule

// File: tb/tb_scie_fir_pipelined.sv
// Directed bench for scie_fir_pipelined: coefficient load, history push/read,
// FIR sum incl. wrap-around, hold/invalid decode, and asynchronous reset.
module tb_scie_fir_pipelined;
    import scie_fir_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] io_insn;
    logic        io_valid;
    logic [31:0] io_rs1;
    logic [31:0] io_rs2;
    logic [31:0] io_rd;

    int total = 0;
    int bad   = 0;

    scie_fir_pipelined dut (
        .clock    (clock),
        .reset    (reset),
        .io_insn  (io_insn),
        .io_valid (io_valid),
        .io_rs1   (io_rs1),
        .io_rs2   (io_rs2),
        .io_rd    (io_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one instruction slot on the falling edge; returns 1 time unit after the rising edge.
    task automatic issue(input logic vld, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        @(negedge clock);
        io_valid = vld;
        io_insn  = {17'h0, f3, 5'h0, op};
        io_rs1   = rs1;
        io_rs2   = rs2;
        @(posedge clock);
        #1;
        io_valid = 1'b0;
        io_insn  = 32'h0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        io_valid = 1'b0;
        io_insn  = 32'h0;
        io_rs1   = 32'h0;
        io_rs2   = 32'h0;
        #2;
        total++;
        if (io_rd !== 32'h0) begin
            bad++; $display("FAIL reset_early io_rd=%h want=%h", io_rd, 32'h0);
        end
        // A READ issued while reset is low must not take effect.
        issue(1'b1, OP_READ, RD_COEF, 32'h0, 32'h0);
        total++;
        if (io_rd !== 32'h0) begin
            bad++; $display("FAIL reset_held io_rd=%h want=%h", io_rd, 32'h0);
        end
        @(negedge clock);
        reset = 1'b1;
        issue(1'b1, OP_READ, RD_PREV, 32'h0, 32'h0);
        total++;
        if (io_rd !== 32'h0) begin
            bad++; $display("FAIL reset_read_prev io_rd=%h want=%h", io_rd, 32'h0);
        end
    endtask

    task automatic test_set_coef();
        logic [31:0] cv [5];
        cv[0] = 32'd4193776; cv[1] = 32'd213188; cv[2] = 32'd104368;
        cv[3] = 32'd3111167; cv[4] = 32'd2030295;
        for (int i = 0; i < 5; i++) issue(1'b1, OP_SET_COEF, 3'd0, cv[i], 32'(i));
        issue(1'b1, OP_READ, RD_COEF, 32'h0, 32'd3);
        total++;
        if (io_rd !== 32'd3111167) begin
            bad++; $display("FAIL coef_rd3 io_rd=%0d want=%0d", io_rd, 3111167);
        end
        issue(1'b1, OP_READ, RD_COEF, 32'h0, 32'd7);
        total++;
        if (io_rd !== 32'h0) begin
            bad++; $display("FAIL coef_rd7 io_rd=%0d want=0", io_rd);
        end
        // Out-of-range index 8 aliases slot 0 in its low bits and must be ignored.
        issue(1'b1, OP_SET_COEF, 3'd0, 32'hDEADBEEF, 32'd8);
        issue(1'b1, OP_SET_COEF, 3'd0, 32'hDEADBEEF, 32'd5);
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, OP_READ, RD_COEF, 32'h0, 32'(i));
            total++;
            if (io_rd !== cv[i]) begin
                bad++; $display("FAIL coef_rd_idx%0d io_rd=%0d want=%0d", i, io_rd, cv[i]);
            end
        end
        issue(1'b1, OP_READ, RD_COEF, 32'h0, 32'd5);
        total++;
        if (io_rd !== 32'h0) begin
            bad++; $display("FAIL coef_rd5 io_rd=%0d want=0", io_rd);
        end
    endtask

    task automatic test_push();
        logic [31:0] prev;
        logic [31:0] smp;
        prev = 32'h0;
        for (int i = 0; i < 20; i++) begin
            case (i)
                0:       smp = 32'd323244;
                1:       smp = 32'd6076607;
                2:       smp = 32'd5578861;
                default: smp = 32'(1000 * i + 7);
            endcase
            issue(1'b1, OP_PUSH, 3'd0, smp, 32'h0);
            issue(1'b0, 7'h00, 3'd0, 32'h0, 32'h0);
            // Operands during READ are noise and must not matter for funct3=0.
            issue(1'b1, OP_READ, RD_PREV, 32'hA5A5A5A5, 32'(i));
            total++;
            if (io_rd !== prev) begin
                bad++; $display("FAIL push_prev%0d io_rd=%0d want=%0d", i, io_rd, prev);
            end
            prev = smp;
        end
    endtask

    task automatic test_fir();
        issue(1'b1, OP_SET_COEF, 3'd0, 32'd1, 32'd0);
        issue(1'b1, OP_SET_COEF, 3'd0, 32'd2, 32'd1);
        issue(1'b1, OP_SET_COEF, 3'd0, 32'd3, 32'd2);
        issue(1'b1, OP_SET_COEF, 3'd0, 32'd0, 32'd3);
        issue(1'b1, OP_SET_COEF, 3'd0, 32'd0, 32'd4);
        issue(1'b1, OP_PUSH, 3'd0, 32'd10, 32'h0);
        issue(1'b1, OP_PUSH, 3'd0, 32'd20, 32'h0);
        issue(1'b1, OP_PUSH, 3'd0, 32'd30, 32'h0);
        issue(1'b1, OP_READ, RD_FIR, 32'h12345678, 32'd9);
        total++;
        if (io_rd !== 32'd100) begin
            bad++; $display("FAIL fir_basic io_rd=%0d want=100", io_rd);
        end
        // Back-to-back PUSH then READ: h = 40,30,20 -> 40 + 60 + 60.
        issue(1'b1, OP_PUSH, 3'd0, 32'd40, 32'h0);
        issue(1'b1, OP_READ, RD_FIR, 32'h0, 32'h0);
        total++;
        if (io_rd !== 32'd160) begin
            bad++; $display("FAIL fir_b2b io_rd=%0d want=160", io_rd);
        end
        // c0=0x7FFFFFFF, h=2,40,30: 0xFFFFFFFE + 80 + 90 wraps to 168.
        issue(1'b1, OP_SET_COEF, 3'd0, 32'h7FFFFFFF, 32'd0);
        issue(1'b1, OP_PUSH, 3'd0, 32'd2, 32'h0);
        issue(1'b1, OP_READ, RD_FIR, 32'h0, 32'h0);
        total++;
        if (io_rd !== 32'd168) begin
            bad++; $display("FAIL fir_wrap io_rd=%0d want=168", io_rd);
        end
        // c1=-3: -2 - 120 + 90 = -32.
        issue(1'b1, OP_SET_COEF, 3'd0, 32'hFFFFFFFD, 32'd1);
        issue(1'b1, OP_READ, RD_FIR, 32'h0, 32'h0);
        total++;
        if (io_rd !== 32'hFFFFFFE0) begin
            bad++; $display("FAIL fir_neg io_rd=%h want=%h", io_rd, 32'hFFFFFFE0);
        end
    endtask

    task automatic test_hold();
        issue(1'b1, OP_READ, RD_COEF, 32'h0, 32'd0);
        total++;
        if (io_rd !== 32'h7FFFFFFF) begin
            bad++; $display("FAIL hold_setup io_rd=%h want=%h", io_rd, 32'h7FFFFFFF);
        end
        issue(1'b0, OP_READ, RD_PREV, 32'h0, 32'h0);
        total++;
        if (io_rd !== 32'h7FFFFFFF) begin
            bad++; $display("FAIL hold_novalid io_rd=%h want=%h", io_rd, 32'h7FFFFFFF);
        end
        issue(1'b1, 7'h33, 3'd0, 32'd999, 32'd0);
        issue(1'b1, 7'h33, 3'd1, 32'd777, 32'd1);
        total++;
        if (io_rd !== 32'h7FFFFFFF) begin
            bad++; $display("FAIL hold_badop io_rd=%h want=%h", io_rd, 32'h7FFFFFFF);
        end
        issue(1'b1, OP_READ, 3'd3, 32'h0, 32'h0);
        total++;
        if (io_rd !== 32'h7FFFFFFF) begin
            bad++; $display("FAIL hold_f3_3 io_rd=%h want=%h", io_rd, 32'h7FFFFFFF);
        end
        // Unknown opcode must not have pushed: h[1] is still 40.
        issue(1'b1, OP_READ, RD_PREV, 32'h0, 32'h0);
        total++;
        if (io_rd !== 32'd40) begin
            bad++; $display("FAIL hold_hist io_rd=%0d want=40", io_rd);
        end
        issue(1'b1, OP_READ, RD_COEF, 32'h0, 32'd1);
        total++;
        if (io_rd !== 32'hFFFFFFFD) begin
            bad++; $display("FAIL hold_coef io_rd=%h want=%h", io_rd, 32'hFFFFFFFD);
        end
    endtask

    task automatic test_async_reset();
        issue(1'b1, OP_READ, RD_COEF, 32'h0, 32'd0);
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (io_rd !== 32'h0) begin
            bad++; $display("FAIL areset_drop io_rd=%h want=0", io_rd);
        end
        @(negedge clock);
        reset = 1'b1;
        issue(1'b1, OP_READ, RD_COEF, 32'h0, 32'd0);
        total++;
        if (io_rd !== 32'h0) begin
            bad++; $display("FAIL areset_coef io_rd=%h want=0", io_rd);
        end
        issue(1'b1, OP_READ, RD_PREV, 32'h0, 32'h0);
        issue(1'b1, OP_READ, RD_FIR, 32'h0, 32'h0);
        total++;
        if (io_rd !== 32'h0) begin
            bad++; $display("FAIL areset_fir io_rd=%h want=0", io_rd);
        end
        issue(1'b1, OP_PUSH, 3'd0, 32'd55, 32'h0);
        issue(1'b1, OP_READ, RD_PREV, 32'h0, 32'h0);
        total++;
        if (io_rd !== 32'h0) begin
            bad++; $display("FAIL areset_prev io_rd=%0d want=0", io_rd);
        end
    endtask

    initial begin
        test_reset();
        test_set_coef();
        test_push();
        test_fir();
        test_hold();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
